// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller:
// width codes, FSM states and decode helpers.
package dmem_ctrl_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    W_WORD,
    W_HALF,
    W_BYTE
  } width_t;

  // Unused codes 101-111 fall back to word
  function automatic width_t width_of(
    input logic [2:0] d
  );
    width_t w;
    w = W_WORD;
    if (d == DM_HALF || d == DM_HALF_U)
      w = W_HALF;
    if (d == DM_BYTE || d == DM_BYTE_U)
      w = W_BYTE;
    return w;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] d,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    if (width_of(d) == W_HALF)
      m = off[0];
    if (width_of(d) == W_WORD)
      m = |off;
    return m;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU-side and SRAM-side signal bundle.
// slave = controller view, master = CPU/SRAM view.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_mem_r;
  logic              cpu_mem_w;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_digit;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              misalign_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  cpu_mem_r, cpu_mem_w,
    input  cpu_addr, cpu_wdata, cpu_digit,
    output cpu_rdata, cpu_stall,
    output misalign_err,
    output ram_en, ram_we,
    output ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_mem_r, cpu_mem_w,
    output cpu_addr, cpu_wdata, cpu_digit,
    input  cpu_rdata, cpu_stall,
    input  misalign_err,
    input  ram_en, ram_we,
    input  ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_ctrl_align.sv
// Lane alignment: load extract/extend and
// sub-word store merge into an old word.
module dmem_ctrl_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_digit,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [31:0] w_sh;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sgn;
  width_t      w_w;

  assign w_sh = i_word >> {i_off, 3'b000};
  assign w_b  = w_sh[7:0];
  assign w_h  = i_off[1] ? i_word[31:16]
                         : i_word[15:0];
  assign w_w  = width_of(i_digit);
  assign w_sgn = (i_digit == DM_BYTE)
              || (i_digit == DM_HALF);

  always_comb begin
    o_load = i_word;
    unique case (w_w)
      W_BYTE:
        o_load = {{24{w_sgn & w_b[7]}}, w_b};
      W_HALF:
        o_load = {{16{w_sgn & w_h[15]}}, w_h};
      default:
        o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    unique case (w_w)
      W_BYTE:
        o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      W_HALF:
        if (i_off[1])
          o_merge[31:16] = i_wdata[15:0];
        else
          o_merge[15:0]  = i_wdata[15:0];
      default:
        o_merge = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: FSM driving a word SRAM
// with read-modify-write for sub-word stores.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_req;
  logic        w_store;
  logic        w_word;
  logic        w_mis;
  logic        w_stall;
  logic        w_en;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_unused_addr;

  assign w_req   = bus.cpu_mem_r | bus.cpu_mem_w;
  assign w_store = bus.cpu_mem_w;
  assign w_word  = width_of(bus.cpu_digit) == W_WORD;
  assign w_mis   = misaligned(bus.cpu_digit,
                              bus.cpu_addr[1:0]);

  assign w_unused_addr = ^bus.cpu_addr[31:ADDR_W+2];

  dmem_ctrl_align u_align (
    .i_word  (bus.ram_rdata),
    .i_wdata (bus.cpu_wdata),
    .i_off   (bus.cpu_addr[1:0]),
    .i_digit (bus.cpu_digit),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_wdata = bus.cpu_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          if (w_mis) begin
            w_next = S_DONE;
          end else if (w_store && w_word) begin
            w_en   = 1'b1;
            w_we   = 1'b1;
            w_next = S_DONE;
          end else begin
            w_en   = 1'b1;
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        w_next  = S_DONE;
        // Second half of read-modify-write
        if (w_store) begin
          w_en    = 1'b1;
          w_we    = 1'b1;
          w_wdata = w_merge;
        end
      end
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE)
              && w_req && w_mis;
      if (r_state == S_WAIT && !w_store)
        r_rdata <= w_load;
    end
  end

  assign bus.cpu_stall    = w_stall;
  assign bus.cpu_rdata    = r_rdata;
  assign bus.misalign_err = r_err;
  assign bus.ram_en       = w_en;
  assign bus.ram_we       = w_we;
  assign bus.ram_addr     = bus.cpu_addr[ADDR_W+1:2];
  assign bus.ram_wdata    = w_wdata;

endmodule
